// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_pkg : shared state encoding and defaults for the PS/2 receiver   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam int PS2_DATA_BITS      = 8;
    localparam int PS2_FILTER_LEN_DEF = 8;
    localparam int PS2_TIMEOUT_DEF    = 60000;

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_line_filter : 2-flop synchroniser followed by a deglitch filter  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = PS2_FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic filtered
);

    localparam int CW = $clog2(FILTER_LEN);

    logic [1:0]    sync_ff;
    logic [CW-1:0] cnt;

    // Count consecutive synchronised samples that disagree with the
    // filtered value; any agreeing sample restarts the run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff  <= 2'b11;
            cnt      <= '0;
            filtered <= 1'b1;
        end else begin
            sync_ff <= {sync_ff[0], raw};
            if (sync_ff[1] == filtered) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                filtered <= sync_ff[1];
                cnt      <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_rx_deframer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_rx_deframer : PS/2 device-to-host frame receiver with watchdog   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ps2_rx_deframer
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = PS2_FILTER_LEN_DEF,
    parameter int TIMEOUT    = PS2_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_kbd_clk,
    input  logic       ps2_kbd_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error
);

    localparam int WDW = $clog2(TIMEOUT);

    logic                     clk_f;
    logic                     data_f;
    logic                     clk_prev;
    logic                     fall;
    ps2_state_t               state;
    logic [2:0]               bit_cnt;
    logic [PS2_DATA_BITS-1:0] shreg;
    logic                     par;
    logic [WDW-1:0]           wd;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk      (clk),
        .reset_n  (reset_n),
        .raw      (ps2_kbd_clk),
        .filtered (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk      (clk),
        .reset_n  (reset_n),
        .raw      (ps2_kbd_data),
        .filtered (data_f)
    );

    assign fall = clk_prev & ~clk_f;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_prev <= 1'b1;
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            shreg    <= '0;
            par      <= 1'b0;
            wd       <= '0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            clk_prev <= clk_f;
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
            // A fall always takes priority over a coincident watchdog expiry.
            if (fall) begin
                wd <= '0;
                case (state)
                    IDLE: begin
                        if (!data_f) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        shreg <= {data_f, shreg[PS2_DATA_BITS-1:1]};
                        if (bit_cnt == 3'(PS2_DATA_BITS - 1)) begin
                            state <= PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    PARITY: begin
                        par   <= data_f;
                        state <= STOP;
                    end
                    STOP: begin
                        if ((^{shreg, par}) && data_f) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_error <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                wd <= '0;
            end else if (wd == WDW'(TIMEOUT - 1)) begin
                rx_error <= 1'b1;
                state    <= IDLE;
                wd       <= '0;
            end else if (wd != '1) begin
                wd <= wd + WDW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_deframer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ps2_rx_deframer : directed frames checked against a frame model   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ps2_rx_deframer;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 3000;
    localparam int HALF       = 100;
    // raw edge -> 2 sync flops -> FILTER_LEN filter samples -> registered strobe
    localparam int LAT        = FILTER_LEN + 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       kclk = 1'b1;
    logic       kdata = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_error = 0;

    int         exp_due[$];
    bit         exp_err[$];
    logic [7:0] exp_byte[$];
    logic [7:0] model_data = 8'h00;
    bit         ev;
    bit         ev_err;

    ps2_rx_deframer #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ps2_kbd_clk  (kclk),
        .ps2_kbd_data (kdata),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_error     (rx_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    // Per-cycle comparison against the expected strobe schedule.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_due.delete();
            exp_err.delete();
            exp_byte.delete();
            model_data = 8'h00;
            chk("reset_valid", {31'd0, rx_valid}, 32'd0);
            chk("reset_error", {31'd0, rx_error}, 32'd0);
            chk("reset_data", {24'd0, rx_data}, 32'd0);
        end else begin
            ev     = 1'b0;
            ev_err = 1'b0;
            while (exp_due.size() > 0 && exp_due[0] < cyc) begin
                chk("missed_event", 32'd0, 32'd1);
                void'(exp_due.pop_front());
                void'(exp_err.pop_front());
                void'(exp_byte.pop_front());
            end
            if (exp_due.size() > 0 && exp_due[0] == cyc) begin
                ev     = 1'b1;
                ev_err = exp_err[0];
                if (!ev_err) model_data = exp_byte[0];
                void'(exp_due.pop_front());
                void'(exp_err.pop_front());
                void'(exp_byte.pop_front());
            end
            chk("rx_valid", {31'd0, rx_valid}, {31'd0, ev & ~ev_err});
            chk("rx_error", {31'd0, rx_error}, {31'd0, ev & ev_err});
            chk("rx_data", {24'd0, rx_data}, {24'd0, model_data});
            if (rx_valid) n_valid++;
            if (rx_error) n_error++;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends the first nbits of a frame; glitch drops the clock for 3 cycles mid-bit.
    task automatic send(input logic [7:0] b, input bit bad_par, input bit stop_v,
                        input int nbits, input bit glitch);
        logic [10:0] fr;
        fr = {stop_v, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            if (glitch && i == 4) begin
                wait_cyc(HALF / 4);
                kclk = 1'b0;
                wait_cyc(3);
                kclk = 1'b1;
                wait_cyc(HALF / 4 - 3);
            end else begin
                wait_cyc(HALF / 2);
            end
            kdata = fr[i];
            wait_cyc(HALF / 2);
            kclk = 1'b0;
            if (i == nbits - 1) begin
                if (nbits == 11) begin
                    exp_due.push_back(cyc + LAT);
                    exp_err.push_back(!(stop_v && !bad_par));
                    exp_byte.push_back(b);
                end else begin
                    exp_due.push_back(cyc + LAT + TIMEOUT);
                    exp_err.push_back(1'b1);
                    exp_byte.push_back(b);
                end
            end
            wait_cyc(HALF);
            kclk = 1'b1;
        end
        kdata = 1'b1;
    endtask

    initial begin
        #(1000000);
        $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        wait_cyc(10);
        @(posedge clk); #2 reset_n = 1'b1;
        wait_cyc(50);

        send(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        wait_cyc(2 * HALF);
        chk("t1_data", {24'd0, rx_data}, 32'h1C);
        chk("t1_valid_count", n_valid, 32'd1);

        send(8'hE0, 1'b0, 1'b1, 11, 1'b0);
        wait_cyc(2 * HALF);
        chk("t2_data_e0", {24'd0, rx_data}, 32'hE0);
        send(8'hF0, 1'b0, 1'b1, 11, 1'b0);
        wait_cyc(2 * HALF);
        chk("t2_data_f0", {24'd0, rx_data}, 32'hF0);
        send(8'h75, 1'b0, 1'b1, 11, 1'b0);
        wait_cyc(2 * HALF);
        chk("t2_data_75", {24'd0, rx_data}, 32'h75);
        chk("t2_valid_count", n_valid, 32'd4);

        send(8'h29, 1'b1, 1'b1, 11, 1'b0);
        wait_cyc(2 * HALF);
        chk("t3_data_kept", {24'd0, rx_data}, 32'h75);
        chk("t3_error_count", n_error, 32'd1);

        send(8'h16, 1'b0, 1'b0, 11, 1'b0);
        wait_cyc(2 * HALF);
        chk("t4_error_count", n_error, 32'd2);
        send(8'h16, 1'b0, 1'b1, 11, 1'b0);
        wait_cyc(2 * HALF);
        chk("t4_data", {24'd0, rx_data}, 32'h16);

        send(8'h5A, 1'b0, 1'b1, 11, 1'b1);
        wait_cyc(2 * HALF);
        chk("t5_data", {24'd0, rx_data}, 32'h5A);
        chk("t5_valid_count", n_valid, 32'd6);

        send(8'hA5, 1'b0, 1'b1, 6, 1'b0);
        wait_cyc(TIMEOUT + LAT + 2 * HALF);
        chk("t6_data_kept", {24'd0, rx_data}, 32'h5A);
        chk("t6_error_count", n_error, 32'd3);

        send(8'h33, 1'b0, 1'b1, 4, 1'b0);
        @(posedge clk); #2 reset_n = 1'b0;
        wait_cyc(5);
        chk("t6_reset_data", {24'd0, rx_data}, 32'h00);
        @(posedge clk); #2 reset_n = 1'b1;
        wait_cyc(2 * HALF);
        send(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        wait_cyc(2 * HALF);
        chk("t6_post_reset_data", {24'd0, rx_data}, 32'h1C);
        wait_cyc(TIMEOUT + LAT);
        chk("final_valid_count", n_valid, 32'd7);
        chk("final_error_count", n_error, 32'd3);
        chk("queue_drained", exp_due.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
